// File: rtl/rv_pkg.sv
// Shared RV32 decode types: decoded bundle, ALU/compare/mul codes, operand and result selects, opcodes.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 30;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 5;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU_CTRL codes
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'h00;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'h01;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'h02;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'h03;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'h04;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'h05;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'h06;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'h07;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'h08;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'h09;

  // ALU_CMP codes (branch comparisons)
  localparam logic [ALU_W-1:0] ALU_CMP_EQ  = 5'h10;
  localparam logic [ALU_W-1:0] ALU_CMP_NE  = 5'h11;
  localparam logic [ALU_W-1:0] ALU_CMP_LT  = 5'h12;
  localparam logic [ALU_W-1:0] ALU_CMP_GE  = 5'h13;
  localparam logic [ALU_W-1:0] ALU_CMP_LTU = 5'h14;
  localparam logic [ALU_W-1:0] ALU_CMP_GEU = 5'h15;

  // MUL codes: base plus funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
  localparam logic [ALU_W-1:0] ALU_MUL    = 5'h18;
  localparam logic [ALU_W-1:0] ALU_MULH   = 5'h19;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 5'h1a;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 5'h1b;
  localparam logic [ALU_W-1:0] ALU_DIV    = 5'h1c;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 5'h1d;
  localparam logic [ALU_W-1:0] ALU_REM    = 5'h1e;
  localparam logic [ALU_W-1:0] ALU_REMU   = 5'h1f;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } alu_src_op1_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } alu_src_op2_e;

  typedef enum logic [1:0] {
    RES_ALU   = 2'd0,
    RES_MEM   = 2'd1,
    RES_PC_P4 = 2'd2,
    RES_CSR   = 2'd3
  } result_src_e;

  typedef enum logic {
    PC_SEL_PC  = 1'b0,
    PC_SEL_RS1 = 1'b1
  } pc_sel_e;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [PC_W-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [2:0]       funct3;
    logic [ALU_W-1:0] alu_ctrl;
    alu_src_op1_e     op1_sel;
    alu_src_op2_e     op2_sel;
    result_src_e      res_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             jump;
    logic             branch;
    pc_sel_e          pc_sel;
    logic             is_mul;
    logic             is_csr;
    logic             inv_instr;
  } rv_dec_t;

  // Integer ALU op from funct3; alt selects SUB/SRA
  function automatic logic [ALU_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch compare code from funct3
  function automatic logic [ALU_W-1:0] alu_cmp(input logic [2:0] f3);
    case (f3)
      3'b001:  return ALU_CMP_NE;
      3'b100:  return ALU_CMP_LT;
      3'b101:  return ALU_CMP_GE;
      3'b110:  return ALU_CMP_LTU;
      3'b111:  return ALU_CMP_GEU;
      default: return ALU_CMP_EQ;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] mul_code(input logic [2:0] f3);
    return ALU_MUL | {2'b00, f3};
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M, +Zicsr) instruction decoder producing one rv_dec_t bundle.
module rv_decode_comb
  import rv_pkg::*;
#(
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic [XLEN-1:0] instr,
  input  logic [PC_W-1:0] pc,
  output rv_dec_t         dec_c
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  rv_dec_t         d;
  logic            legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Immediate formats
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Field decode; illegal words pass through with side-effect flags cleared
  always_comb begin
    legal      = 1'b1;
    d          = '0;
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.pc       = pc;
    d.funct3   = f3;
    d.alu_ctrl = ALU_ADD;
    d.op1_sel  = OP1_RS1;
    d.op2_sel  = OP2_RS2;
    d.res_src  = RES_ALU;
    d.pc_sel   = PC_SEL_PC;

    case (opcode)
      OPC_LOAD: begin
        legal       = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        d.imm       = imm_i;
        d.op2_sel   = OP2_IMM;
        d.res_src   = RES_MEM;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal       = !f3[2] && (f3 != 3'b011);
        d.imm       = imm_s;
        d.op2_sel   = OP2_IMM;
        d.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == F7_BASE);
        else if (f3 == 3'b101) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        d.imm       = imm_i;
        d.op2_sel   = OP2_IMM;
        d.alu_ctrl  = alu_base(f3, (f3 == 3'b101) && instr[30]);
        d.reg_write = 1'b1;
      end
      OPC_OP: begin
        d.reg_write = 1'b1;
        if (f7 == F7_MULDIV) begin
          legal      = EN_M;
          d.is_mul   = 1'b1;
          d.alu_ctrl = mul_code(f3);
        end else if ((f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          d.alu_ctrl = alu_base(f3, instr[30]);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_LUI: begin
        d.imm       = imm_u;
        d.op1_sel   = OP1_ZERO;
        d.op2_sel   = OP2_IMM;
        d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d.imm       = imm_u;
        d.op1_sel   = OP1_PC;
        d.op2_sel   = OP2_IMM;
        d.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
        d.imm      = imm_b;
        d.alu_ctrl = alu_cmp(f3);
        d.branch   = 1'b1;
      end
      OPC_JAL: begin
        d.imm       = imm_j;
        d.op1_sel   = OP1_PC;
        d.op2_sel   = OP2_IMM;
        d.res_src   = RES_PC_P4;
        d.jump      = 1'b1;
        d.reg_write = 1'b1;
      end
      OPC_JALR: begin
        legal       = (f3 == 3'b000);
        d.imm       = imm_i;
        d.op2_sel   = OP2_IMM;
        d.res_src   = RES_PC_P4;
        d.pc_sel    = PC_SEL_RS1;
        d.jump      = 1'b1;
        d.reg_write = 1'b1;
      end
      OPC_MISC_MEM: begin
        legal = (f3[2:1] == 2'b00);
      end
      OPC_SYSTEM: begin
        if (EN_ZICSR && (f3 != 3'b000) && (f3 != 3'b100)) begin
          d.imm       = XLEN'(instr[19:15]);
          d.op2_sel   = OP2_IMM;
          d.res_src   = RES_CSR;
          d.is_csr    = 1'b1;
          d.reg_write = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    if (d.rd == '0) d.reg_write = 1'b0;

    if (!legal) begin
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.jump      = 1'b0;
      d.branch    = 1'b0;
      d.is_mul    = 1'b0;
      d.is_csr    = 1'b0;
      d.inv_instr = 1'b1;
    end
  end

  assign dec_c = d;

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage: valid/ready handshake, optional one-entry skid buffer, registered bundle.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1,
  parameter bit EN_SKID  = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output rv_dec_t         o_dec
);

  logic [XLEN-1:0] mux_instr;
  logic [PC_W-1:0] mux_pc;
  rv_dec_t         mux_dec;
  logic            in_fire_c;
  logic            out_free_c;

  assign in_fire_c  = i_valid && o_ready;
  assign out_free_c = !o_valid || i_ready;

  rv_decode_comb #(
    .EN_M     (EN_M),
    .EN_ZICSR (EN_ZICSR)
  ) u_decode (
    .instr (mux_instr),
    .pc    (mux_pc),
    .dec_c (mux_dec)
  );

  if (EN_SKID) begin : g_skid
    logic            skid_full;
    logic [XLEN-1:0] skid_instr;
    logic [PC_W-1:0] skid_pc;

    // A held skid entry always takes precedence over the live input
    assign mux_instr = skid_full ? skid_instr : i_instr;
    assign mux_pc    = skid_full ? skid_pc    : i_pc;
    assign o_ready   = !skid_full;

    // Output register and skid entry update; reset beats flush beats transfers
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        o_valid    <= 1'b0;
        o_dec      <= '0;
        skid_full  <= 1'b0;
        skid_instr <= '0;
        skid_pc    <= '0;
      end else if (i_flush) begin
        o_valid   <= 1'b0;
        skid_full <= 1'b0;
      end else if (out_free_c) begin
        o_valid   <= skid_full || in_fire_c;
        skid_full <= 1'b0;
        if (skid_full || in_fire_c) o_dec <= mux_dec;
      end else if (in_fire_c) begin
        skid_instr <= i_instr;
        skid_pc    <= i_pc;
        skid_full  <= 1'b1;
      end
    end
  end else begin : g_noskid
    assign mux_instr = i_instr;
    assign mux_pc    = i_pc;
    assign o_ready   = out_free_c;

    // Single output register; ready passes straight through from downstream
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        o_valid <= 1'b0;
        o_dec   <= '0;
      end else if (i_flush) begin
        o_valid <= 1'b0;
      end else if (in_fire_c) begin
        o_valid <= 1'b1;
        o_dec   <= mux_dec;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
